// File: rtl/hilo_div_ctrl_if.sv
// hilo_div_ctrl_if: execute-stage, divider and multiplier signals of the HI/LO sequencer
//   op_valid/op/rs_val/rt_val          : op presented by the execute stage
//   stall/hi/lo                        : pipeline hold and architectural HI/LO
//   div_start/div_dividend/div_divisor/div_signed, div_busy/div_q/div_r : iterative divider
//   mul_a/mul_b/mul_signed, mul_hi/mul_lo                               : combinational multiplier
//   modport slave is the sequencer side, modport master the environment side.
interface hilo_div_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
);
    logic             op_valid;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_start;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_signed;
    logic             div_busy;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_signed;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    modport slave (
        input  op_valid, op, rs_val, rt_val, div_busy, div_q, div_r, mul_hi, mul_lo,
        output stall, hi, lo, div_start, div_dividend, div_divisor, div_signed,
               mul_a, mul_b, mul_signed
    );

    modport master (
        output op_valid, op, rs_val, rt_val, div_busy, div_q, div_r, mul_hi, mul_lo,
        input  stall, hi, lo, div_start, div_dividend, div_divisor, div_signed,
               mul_a, mul_b, mul_signed
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: owns HI/LO, writes multiply results, sequences the iterative divider
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : execute-stage op, stall, hi/lo, divider and multiplier links
//   Optional macro DIVZERO_SKIP_EN: a zero divisor retires without launching the divider.
module hilo_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input logic            clock,
    input logic            reset,
    hilo_div_ctrl_if.slave bus
);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(6);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] hi_q, hi_n, lo_q, lo_n;
    logic [WIDTH-1:0] dividend_q, divisor_q;
    logic             signed_q;
    logic             seen_busy, seen_n;
    logic             div_lat, stall, start;
    logic             is_div, zero_skip;

    assign is_div = bus.op == OP_DIV || bus.op == OP_DIVU;

`ifdef DIVZERO_SKIP_EN
    assign zero_skip = bus.rt_val == '0;
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_n = state;
        hi_n    = hi_q;
        lo_n    = lo_q;
        seen_n  = seen_busy;
        div_lat = 1'b0;
        stall   = 1'b0;
        start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.op_valid) begin
                    if (bus.op == OP_MULT || bus.op == OP_MULTU) begin
                        hi_n = bus.mul_hi;
                        lo_n = bus.mul_lo;
                    end else if (bus.op == OP_MTHI) begin
                        hi_n = bus.rs_val;
                    end else if (bus.op == OP_MTLO) begin
                        lo_n = bus.rs_val;
                    end else if (is_div) begin
                        stall   = 1'b1;
                        div_lat = 1'b1;
                        state_n = zero_skip ? DONE : ISSUE;
                    end
                end
            end
            ISSUE: begin
                start   = 1'b1;
                stall   = 1'b1;
                seen_n  = 1'b0;
                state_n = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                // a low div_busy only means "finished" once the divider has been seen running
                seen_n = seen_busy | bus.div_busy;
                if (seen_busy && !bus.div_busy) begin
                    lo_n    = bus.div_q;
                    hi_n    = bus.div_r;
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signed_q   <= 1'b0;
            seen_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            hi_q      <= hi_n;
            lo_q      <= lo_n;
            seen_busy <= seen_n;
            if (div_lat) begin
                dividend_q <= bus.rs_val;
                divisor_q  <= bus.rt_val;
                signed_q   <= bus.op == OP_DIV;
            end
        end
    end

    assign bus.stall        = stall;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.div_start    = start;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.div_signed   = signed_q;
    assign bus.mul_a        = bus.rs_val;
    assign bus.mul_b        = bus.rt_val;
    assign bus.mul_signed   = bus.op == OP_MULT;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb_hilo_div_ctrl: scoreboard bench for hilo_div_ctrl with a behavioural divider and HI/LO model
module tb_hilo_div_ctrl;
    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
        int          starts;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic        dsg;
        bit          is_mul;
        logic        msg;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 1'b0;
    int   div_delay = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    exp_t sb[$];

    hilo_div_ctrl_if #(.WIDTH(32), .OP_W(3)) bus ();
    hilo_div_ctrl #(.WIDTH(32), .OP_W(3)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    function automatic logic [31:0] dq(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb_;
        if (b == 0) return '1;
        sa  = s ? longint'($signed(a)) : longint'(a);
        sb_ = s ? longint'($signed(b)) : longint'(b);
        return 32'(sa / sb_);
    endfunction

    function automatic logic [31:0] dr(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb_;
        if (b == 0) return a;
        sa  = s ? longint'($signed(a)) : longint'(a);
        sb_ = s ? longint'($signed(b)) : longint'(b);
        return 32'(sa % sb_);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // divider: busy rises div_delay cycles late, runs 32 cycles, results appear as busy falls
    logic        dbusy = 1'b0;
    logic [31:0] dqr = '0;
    logic [31:0] drr = '0;
    logic [31:0] da, db;
    logic        ds;
    int          pre = 0;
    int          cnt = 0;
    bit          act = 1'b0;
    assign bus.div_busy = dbusy;
    assign bus.div_q    = dqr;
    assign bus.div_r    = drr;

    always @(posedge clock) begin
        if (bus.div_start) begin
            da    <= bus.div_dividend;
            db    <= bus.div_divisor;
            ds    <= bus.div_signed;
            pre   <= div_delay;
            cnt   <= 32;
            act   <= 1'b1;
            dbusy <= div_delay == 0;
            dqr   <= 32'hDEAD_0000;
            drr   <= 32'hDEAD_0001;
        end else if (act) begin
            if (pre > 1) pre <= pre - 1;
            else if (pre == 1) begin
                pre   <= 0;
                dbusy <= 1'b1;
            end else if (cnt == 1) begin
                dbusy <= 1'b0;
                act   <= 1'b0;
                dqr   <= dq(da, db, ds);
                drr   <= dr(da, db, ds);
            end else cnt <= cnt - 1;
        end
    end

    // monitor: counts stall cycles and launches per op, checks HI/LO after retirement
    int   mst = 0;
    int   mns = 0;
    exp_t me;
    initial begin
        forever begin
            @(negedge clock);
            if (!mon_on) begin
                mst = 0;
                mns = 0;
            end else begin
                if (bus.div_start) begin
                    mns++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_div_start actual=1 required=0");
                    end else begin
                        me = sb[0];
                        chk({me.name, "_div_dividend"}, bus.div_dividend, me.dvd);
                        chk({me.name, "_div_divisor"}, bus.div_divisor, me.dvs);
                        chk({me.name, "_div_signed"}, 32'(bus.div_signed), 32'(me.dsg));
                    end
                end
                if (!bus.op_valid && bus.stall) chk("stall_without_op", 32'(bus.stall), 32'd0);
                if (bus.op_valid && sb.size() > 0) begin
                    me = sb[0];
                    if (me.is_mul) begin
                        chk({me.name, "_mul_signed"}, 32'(bus.mul_signed), 32'(me.msg));
                        chk({me.name, "_mul_a"}, bus.mul_a, me.rs);
                        chk({me.name, "_mul_b"}, bus.mul_b, me.rt);
                    end
                    if (bus.stall) mst++;
                    else begin
                        void'(sb.pop_front());
                        chk({me.name, "_stall_cycles"}, 32'(mst), 32'(me.stalls));
                        chk({me.name, "_div_starts"}, 32'(mns), 32'(me.starts));
                        mst = 0;
                        mns = 0;
                        @(posedge clock);
                        #1;
                        chk({me.name, "_hi"}, bus.hi, me.hi);
                        chk({me.name, "_lo"}, bus.lo, me.lo);
                    end
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] mh, input logic [31:0] ml,
                         input int gap);
        exp_t e;
        int   n;
        bit   skip;
        repeat (gap) begin
            bus.op_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        e.name = nm; e.stalls = 0; e.starts = 0; e.dvd = rs; e.dvs = rt;
        e.dsg = o == 3'd3; e.is_mul = o == 3'd1 || o == 3'd2; e.msg = o == 3'd1;
        e.rs = rs; e.rt = rt;
`ifdef DIVZERO_SKIP_EN
        skip = rt == 0;
`else
        skip = 1'b0;
`endif
        if (e.is_mul) begin
            m_hi = mh;
            m_lo = ml;
        end else if (o == 3'd5) m_hi = rs;
        else if (o == 3'd6) m_lo = rs;
        else if (o == 3'd3 || o == 3'd4) begin
            if (skip) e.stalls = 1;
            else begin
                e.stalls = 35 + div_delay;
                e.starts = 1;
                m_lo = dq(rs, rt, e.dsg);
                m_hi = dr(rs, rt, e.dsg);
            end
        end
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        bus.op_valid = 1'b1;
        bus.op = o;
        bus.rs_val = rs;
        bus.rt_val = rt;
        bus.mul_hi = mh;
        bus.mul_lo = ml;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.stall && n < 200);
        if (bus.stall) begin
            $display("FAIL %s_retire_timeout actual=stalled required=retired", nm);
            $fatal(1, "retire timeout");
        end
        @(posedge clock);
        #1;
        bus.op_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [2:0] o;
        bus.op_valid = 1'b0;
        bus.op = '0;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.mul_hi = '0;
        bus.mul_lo = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_div_start", 32'(bus.div_start), 32'd0);
        chk("rst_div_dividend", bus.div_dividend, 32'd0);
        chk("rst_div_divisor", bus.div_divisor, 32'd0);
        chk("rst_div_signed", 32'(bus.div_signed), 32'd0);
        mon_on = 1'b1;

        div_delay = 0;
        issue("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, '0, '0, 1);
        issue("divu_8000_3", 3'd4, 32'h8000_0000, 32'd3, '0, '0, 1);
        issue("mult", 3'd1, 32'h1111, 32'h2222, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
        issue("multu", 3'd2, 32'h3333, 32'h4444, 32'h0BAD_F00D, 32'h1234_0000, 0);
        issue("mthi", 3'd5, 32'h1234_5678, '0, '0, '0, 0);
        issue("mtlo", 3'd6, 32'h9ABC_DEF0, '0, '0, '0, 0);
        issue("pre_hi", 3'd5, 32'hA, '0, '0, '0, 1);
        issue("pre_lo", 3'd6, 32'hB, '0, '0, '0, 0);
        div_delay = 2;
        issue("div_zero", 3'd3, 32'h1234, 32'd0, '0, '0, 0);
        issue("none", 3'd0, 32'h5555, 32'h6666, 32'h7777, 32'h8888, 0);
        issue("reserved", 3'd7, 32'h5555, 32'h6666, 32'h7777, 32'h8888, 0);

        @(posedge clock);
        #1;
        mon_on = 1'b0;
        div_delay = 0;
        bus.op_valid = 1'b1;
        bus.op = 3'd3;
        bus.rs_val = 32'd55;
        bus.rt_val = 32'd5;
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        chk("mid_div_stall", 32'(bus.stall), 32'd1);
        reset = 1'b1;
        bus.op_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("post_rst_stall", 32'(bus.stall), 32'd0);
        chk("post_rst_hi", bus.hi, 32'd0);
        chk("post_rst_lo", bus.lo, 32'd0);
        @(posedge clock);
        #1;
        chk("post_rst_idle_stall", 32'(bus.stall), 32'd0);
        n = 0;
        while (dbusy && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("stale_busy_fell", 32'(dbusy), 32'd0);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk("stale_result_hi", bus.hi, 32'd0);
        chk("stale_result_lo", bus.lo, 32'd0);
        chk("stale_result_stall", 32'(bus.stall), 32'd0);
        m_hi = '0;
        m_lo = '0;
        mon_on = 1'b1;
        issue("div_100_7", 3'd3, 32'd100, 32'd7, '0, '0, 0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            div_delay = $urandom_range(0, 3);
            issue($sformatf("rnd%0d_op%0d", i, o), o, $urandom,
                  ($urandom_range(0, 6) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom,
                  $urandom, $urandom, $urandom_range(0, 2));
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Sequencing unit between the decode/execute stage and the iterative divider. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO ops and owns the HI/LO architectural registers.
- Launches the divider and stalls the pipeline until the quotient and remainder return, then writes them into LO and HI.
- Writes multiply results from the external combinational multiplier into HI/LO in a single cycle.
- Drives hi/lo continuously for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand/HI/LO width
- OP_W, 3, op code width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  op presented by execute stage
- op  in  OP_W  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=reserved (ignored)
- rs_val  in  WIDTH  rs operand (dividend / multiplicand / MT source)
- rt_val  in  WIDTH  rt operand (divisor / multiplier)
- stall  out  1  hold pipeline
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- div_start  out  1  one-cycle launch pulse to divider
- div_dividend  out  WIDTH  registered dividend
- div_divisor  out  WIDTH  registered divisor
- div_signed  out  1  1 for DIV, 0 for DIVU; the divider honours it
- div_busy  in  1  divider busy
- div_q  in  WIDTH  divider quotient
- div_r  in  WIDTH  divider remainder
- mul_a  out  WIDTH  = rs_val (combinational)
- mul_b  out  WIDTH  = rt_val (combinational)
- mul_signed  out  1  1 when op==MULT
- mul_hi  in  WIDTH  product upper half
- mul_lo  in  WIDTH  product lower half

Behaviour:
- Reset: state=IDLE; hi=lo=0; div_start=0; div_dividend=div_divisor=0; div_signed=0; seen_busy=0. Reset mid-divide abandons the op. Divider results arriving after reset are ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - op_valid && MULT/MULTU: hi<=mul_hi, lo<=mul_lo at the edge. No stall.
  - MTHI: hi<=rs_val. MTLO: lo<=rs_val. Single cycle, no stall.
  - DIV/DIVU: latch rs_val/rt_val/div_signed. stall=1 combinationally this cycle. Next state ISSUE.
  - NONE/reserved: no effect.
- ISSUE: div_start=1 for exactly one cycle; clear seen_busy; stall=1; next state WAIT.
- WAIT:
  - stall=1.
  - Set seen_busy when div_busy==1.
  - When seen_busy && !div_busy: lo<=div_q, hi<=div_r; next state DONE.
  - div_busy low before it has ever been seen high does not complete the op.
- DONE: stall=0 for one cycle so the held DIV instruction retires. op_valid is ignored this cycle (no re-issue). Next state IDLE.
- Latency with a 32-iteration divider:
  - Accept cycle T0, div_start at T1, div_busy high T2..T33.
  - Capture at the end of T34; DONE at T35.
  - stall is high T0..T34 (35 cycles).
- hi/lo outputs are registered. A write becomes visible the cycle after its edge. MFHI immediately after MTHI reads the new value one cycle later; the pipeline's own hazard logic covers this.
- Divider interface: div_dividend, div_divisor and div_signed are held stable from ISSUE through DONE.
- Widths: all datapaths are WIDTH bits. Multiply halves are taken verbatim; no sign handling in this block.

Optional Feature:
- Macro DIVZERO_SKIP_EN.
- Defined: DIV/DIVU with rt_val==0 goes IDLE→DONE directly, with stall=1 only in the accept cycle. No div_start is issued, and hi/lo are unchanged.
- Not defined: a zero divisor runs the normal divider sequence and whatever div_q/div_r the divider returns is written.

Test Plan:
- DIV rs=0xFFFFFFF9 (−7), rt=2 → one div_start pulse, div_signed=1, stall 35 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DONE cycle stall=0 with op_valid held, and no second div_start.
- DIVU rs=0x80000000, rt=3 → div_signed=0; lo=0x2AAAAAAA, hi=0x00000002.
- MULT with mul_hi=0xFFFFFFFF, mul_lo=0xFFFFFFFA → no stall; hi/lo take those values the next cycle; mul_signed=1. For MULTU, mul_signed=0.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on back-to-back cycles → hi=0x12345678, lo=0x9ABCDEF0; no stall.
- DIV rt=0 with hi=0xA, lo=0xB preloaded:
  - With DIVZERO_SKIP_EN: stall 1 cycle, no div_start, hi/lo unchanged.
  - Without it: full 35-cycle stall, hi/lo = divider output.
- reset pulsed during WAIT (T10) → next cycle state IDLE, stall=0, hi=lo=0. A later div_busy fall causes no write; a following DIV 100/7 completes normally with lo=14, hi=2.
